// File: rtl/reset_req_ctrl_if.sv
// Purpose: groups the reset-request controller's request inputs and status
// outputs into one bundle.
//   master : drives btn_reset_n, sw_reset, sw_key; observes the status outputs
//   slave  : the controller; drives reset_req, busy, reset_cause, sw_ack
interface reset_req_ctrl_if;
  logic       btn_reset_n;  // raw front-panel button, active-low, async
  logic       sw_reset;     // one-cycle software reset strobe
  logic [7:0] sw_key;       // key qualifying sw_reset
  logic       reset_req;    // high = hold system in reset
  logic       busy;         // high while a pulse or holdoff is running
  logic [1:0] reset_cause;  // 0 power-on, 1 button, 2 software
  logic       sw_ack;       // one-cycle ack of an accepted software request

  modport master (
    output btn_reset_n, sw_reset, sw_key,
    input  reset_req, busy, reset_cause, sw_ack
  );

  modport slave (
    input  btn_reset_n, sw_reset, sw_key,
    output reset_req, busy, reset_cause, sw_ack
  );
endinterface

// File: rtl/reset_req_ctrl.sv
// Purpose: turns a bouncing front-panel button, a keyed software strobe and
// power-on into a stretched, rate-limited system reset request.
// Ports:
//   sysclk  - system clock
//   reset_n - asynchronous active-low reset (starts a power-on pulse)
//   bus     - reset_req_ctrl_if.slave: button/software inputs, status outputs
module reset_req_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 28636,
  parameter int unsigned PULSE_CYCLES    = 64,
  parameter int unsigned HOLDOFF_CYCLES  = 1024
) (
  input  logic              sysclk,
  input  logic              reset_n,
  reset_req_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0]       SW_KEY_OK  = 8'hA5;
  localparam logic [1:0]       CAUSE_POR  = 2'd0;
  localparam logic [1:0]       CAUSE_BTN  = 2'd1;
  localparam logic [1:0]       CAUSE_SW   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             btn_evt_c, sw_evt_c;

  // Debouncer: level follows the synchronized button only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_d   = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
  end

  // Press is the falling edge of the debounced level; release is ignored.
  assign btn_evt_c = level_prev_q & ~level_q;
  assign sw_evt_c  = bus.sw_reset & (bus.sw_key == SW_KEY_OK);

  // Sequencer: IDLE -> PULSE -> HOLDOFF -> IDLE, one shared down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Button has priority when both arrive together.
        if (btn_evt_c) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LOAD;
          cause_d = CAUSE_BTN;
        end else if (sw_evt_c) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LOAD;
          cause_d = CAUSE_SW;
          ack_d   = 1'b1;
        end
      end
      ST_PULSE: begin
        // A held button keeps reloading, stretching the pulse past release.
        if (!level_q) begin
          cnt_d = PULSE_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d  = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  // All state; reset starts a power-on pulse.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      deb_cnt_q    <= '0;
      state_q      <= ST_PULSE;
      cnt_q        <= PULSE_LOAD;
      cause_q      <= CAUSE_POR;
      req_q        <= 1'b1;
      busy_q       <= 1'b1;
      ack_q        <= 1'b0;
    end else begin
      sync1_q      <= bus.btn_reset_n;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.reset_req   = req_q;
  assign bus.busy        = busy_q;
  assign bus.reset_cause = cause_q;
  assign bus.sw_ack      = ack_q;

endmodule
